pio_host_arb: RTL and testbench

- Arbitrates the single host command port of the pio block (action/mindex/index/din in, dout out) between NUM_REQ independent requesters, e.g. CPU bridge and DMA/program loader.
- Sequences each command as a one-cycle action pulse, so action is NONE in every other cycle.
- Applies flow control from tx_full/rx_empty and routes PULL and version-read data back to the requester that issued the command.

---
 rtl/pio_host_pkg.sv | 38 +++
 rtl/pio_rr_arb.sv | 47 ++++
 rtl/pio_host_arb.sv | 162 ++++++++++++++++
 tb/tb_pio_host_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_host_pkg.sv
// rtl/pio_host_pkg.sv - shared action codes, FSM encoding and command type for pio_host_arb
package pio_host_pkg;

    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_PULL  = 4'd3;
    localparam logic [3:0] ACT_PUSH  = 4'd4;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_SIDES = 4'd8;
    localparam logic [3:0] ACT_IMM   = 4'd9;
    localparam logic [3:0] ACT_SHIFT = 4'd10;
    localparam logic [3:0] ACT_LAST  = ACT_SHIFT;

    localparam logic [31:0] PIO_VERSION = 32'h0100_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]  action;
        logic [1:0]  mindex;
        logic [4:0]  index;
        logic [31:0] din;
    } cmd_t;

    // NONE reads back the version word on dout, so it is treated like PULL.
    function automatic logic is_read(input logic [3:0] action);
        return (action == ACT_NONE) || (action == ACT_PULL);
    endfunction

endpackage

// File: rtl/pio_rr_arb.sv
// rtl/pio_rr_arb.sv - generic round-robin arbiter with a registered start pointer
module pio_rr_arb #(
    parameter int NUM_REQ = 2,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PW-1:0]      o_ptr
);

    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0] w_grant;

    // Scan from the farthest slot back to r_ptr so the closest eligible requester wins last.
    always_comb begin
        w_grant    = '0;
        w_win      = '0;
        w_ptr_next = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (i_eligible[idx]) begin
                w_grant      = '0;
                w_grant[idx] = 1'b1;
                w_win        = PW'(idx);
            end
        end
        w_ptr_next = PW'((int'(w_win) + 1) % NUM_REQ);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && (|w_grant)) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_grant = w_grant;
    assign o_ptr   = r_ptr;

endmodule

// File: rtl/pio_host_arb.sv
// rtl/pio_host_arb.sv - arbitrates NUM_REQ requesters onto the single pio host command port
module pio_host_arb
    import pio_host_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int NUM_MACHINES = 4,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [4*NUM_REQ-1:0]    i_req_action,
    input  logic [2*NUM_REQ-1:0]    i_req_mindex,
    input  logic [5*NUM_REQ-1:0]    i_req_index,
    input  logic [32*NUM_REQ-1:0]   i_req_din,
    output logic [NUM_REQ-1:0]      o_resp_valid,
    output logic [31:0]             o_resp_data,
    output logic [3:0]              o_pio_action,
    output logic [1:0]              o_pio_mindex,
    output logic [4:0]              o_pio_index,
    output logic [31:0]             o_pio_din,
    input  logic [31:0]             i_pio_dout,
    input  logic [NUM_MACHINES-1:0] i_pio_tx_full,
    input  logic [NUM_MACHINES-1:0] i_pio_rx_empty
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_run;
    logic               r_is_read;
    logic [3:0]         r_pio_action;
    logic [1:0]         r_pio_mindex;
    logic [4:0]         r_pio_index;
    logic [31:0]        r_pio_din;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [31:0]        r_resp_data;

    logic [3:0]         w_txf;
    logic [3:0]         w_rxe;
    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant;
    logic [PW-1:0]      w_rr_ptr;
    logic               w_accept;
    cmd_t               w_cmd;
    logic [NUM_REQ-1:0] w_owner;

    assign w_txf = 4'(i_pio_tx_full);
    assign w_rxe = 4'(i_pio_rx_empty);

    // Only IDLE may grant; r_run keeps ready low until the first clock after reset.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [3:0] act;
            logic [1:0] mi;
            logic       blocked;
            act        = i_req_action[4*i +: 4];
            mi         = i_req_mindex[2*i +: 2];
            blocked    = ((act == ACT_PUSH) && w_txf[mi]) ||
                         ((act == ACT_PULL) && w_rxe[mi]);
            w_eligible[i] = i_req_valid[i] && !blocked;
        end
        if ((r_state != ST_IDLE) || !r_run) begin
            w_eligible = '0;
        end
    end

    pio_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_eligible (w_eligible),
        .i_advance  (w_accept),
        .o_grant    (w_grant),
        .o_ptr      (w_rr_ptr)
    );

    always_comb begin
        w_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_cmd.action = i_req_action[4*i +: 4];
                w_cmd.mindex = i_req_mindex[2*i +: 2];
                w_cmd.index  = i_req_index[5*i +: 5];
                w_cmd.din    = i_req_din[32*i +: 32];
            end
        end
    end

    // The pointer sits one past the winner until the next accept, so it names the owner.
    always_comb begin
        int oidx;
        w_owner       = '0;
        oidx          = (int'(w_rr_ptr) + NUM_REQ - 1) % NUM_REQ;
        w_owner[oidx] = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE:  w_state_next = ST_SETTLE;
            ST_SETTLE: w_state_next = r_is_read ? ST_RESP : ST_IDLE;
            ST_RESP:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run        <= 1'b0;
            r_is_read    <= 1'b0;
            r_pio_action <= ACT_NONE;
            r_pio_mindex <= '0;
            r_pio_index  <= '0;
            r_pio_din    <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_run        <= 1'b1;
            r_resp_valid <= '0;
            if (w_accept) begin
                r_pio_action <= (w_cmd.action > ACT_LAST) ? ACT_NONE : w_cmd.action;
                r_pio_mindex <= w_cmd.mindex;
                r_pio_index  <= w_cmd.index;
                r_pio_din    <= w_cmd.din;
                r_is_read    <= is_read(w_cmd.action);
            end else if (r_state == ST_ISSUE) begin
                r_pio_action <= ACT_NONE;
            end
            if (r_state == ST_RESP) begin
                r_resp_valid <= w_owner;
                r_resp_data  <= i_pio_dout;
            end
        end
    end

    assign o_req_ready  = w_grant;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_pio_action = r_pio_action;
    assign o_pio_mindex = r_pio_mindex;
    assign o_pio_index  = r_pio_index;
    assign o_pio_din    = r_pio_din;

endmodule

// File: tb/tb_pio_host_arb.sv
// tb/tb_pio_host_arb.sv - scoreboard bench for pio_host_arb
module tb_pio_host_arb;
    import pio_host_pkg::*;

    localparam int NR = 2;
    localparam int NM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [4*NR-1:0]  req_action;
    logic [2*NR-1:0]  req_mindex;
    logic [5*NR-1:0]  req_index;
    logic [32*NR-1:0] req_din;
    logic [NR-1:0] resp_valid;
    logic [31:0]   resp_data;
    logic [3:0]    pio_action;
    logic [1:0]    pio_mindex;
    logic [4:0]    pio_index;
    logic [31:0]   pio_din;
    logic [31:0]   pio_dout;
    logic [NM-1:0] pio_tx_full;
    logic [NM-1:0] pio_rx_empty;

    always #5 clk = ~clk;

    pio_host_arb #(
        .NUM_REQ      (NR),
        .NUM_MACHINES (NM)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_action   (req_action),
        .i_req_mindex   (req_mindex),
        .i_req_index    (req_index),
        .i_req_din      (req_din),
        .o_resp_valid   (resp_valid),
        .o_resp_data    (resp_data),
        .o_pio_action   (pio_action),
        .o_pio_mindex   (pio_mindex),
        .o_pio_index    (pio_index),
        .o_pio_din      (pio_din),
        .i_pio_dout     (pio_dout),
        .i_pio_tx_full  (pio_tx_full),
        .i_pio_rx_empty (pio_rx_empty)
    );

    typedef struct {
        logic [3:0]  a;
        logic [1:0]  m;
        logic [4:0]  ix;
        logic [31:0] d;
    } iss_t;

    typedef struct {
        int          owner;
        logic [31:0] d;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    iss_t mon_iss;
    rsp_t mon_rsp;
    int   acc_cyc [NR];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic [3:0] prev_act = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_iss(input logic [3:0] a, input logic [1:0] m, input logic [4:0] ix, input logic [31:0] d);
        iss_t e;
        e.a = a; e.m = m; e.ix = ix; e.d = d;
        iss_q.push_back(e);
    endtask

    task automatic push_rsp(input int owner, input logic [31:0] d);
        rsp_t e;
        e.owner = owner; e.d = d;
        rsp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input int r, input logic [3:0] a, input logic [1:0] m, input logic [4:0] ix, input logic [31:0] d);
        int n;
        n = 0;
        req_action[4*r +: 4] = a;
        req_mindex[2*r +: 2] = m;
        req_index[5*r +: 5]  = ix;
        req_din[32*r +: 32]  = d;
        req_valid[r]         = 1'b1;
        #1;
        while (!req_ready[r] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req%0d got no ready, required ready within 100 cycles", r);
            req_valid[r] = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            acc_cyc[r]   = cyc;
            req_valid[r] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (pio_action != ACT_NONE) begin
            chk("pulse_gap", 64'(prev_act), 64'(ACT_NONE));
            if (iss_q.size() == 0) begin
                chk("unexpected_issue", 64'(pio_action), 64'(ACT_NONE));
            end else begin
                mon_iss = iss_q.pop_front();
                chk("issue_action", 64'(pio_action), 64'(mon_iss.a));
                chk("issue_mindex", 64'(pio_mindex), 64'(mon_iss.m));
                chk("issue_index",  64'(pio_index),  64'(mon_iss.ix));
                chk("issue_din",    64'(pio_din),    64'(mon_iss.d));
            end
        end
        prev_act = pio_action;
    end

    always @(negedge clk) begin
        if (|resp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                mon_rsp = rsp_q.pop_front();
                chk("resp_owner",   64'(resp_valid), 64'd1 << mon_rsp.owner);
                chk("resp_data",    64'(resp_data),  64'(mon_rsp.d));
                chk("resp_latency", 64'(cyc - acc_cyc[mon_rsp.owner]), 64'd3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_action   = '0;
        req_mindex   = '0;
        req_index    = '0;
        req_din      = '0;
        pio_dout     = '0;
        pio_tx_full  = '0;
        pio_rx_empty = '1;
        acc_cyc[0]   = 0;
        acc_cyc[1]   = 0;

        // reset state, with a request pending so ready is meaningfully gated
        req_action[3:0] = ACT_INSTR;
        req_valid[0]    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pio_action", 64'(pio_action), 64'd0);
        chk("rst_pio_mindex", 64'(pio_mindex), 64'd0);
        chk("rst_pio_index",  64'(pio_index),  64'd0);
        chk("rst_pio_din",    64'(pio_din),    64'd0);
        chk("rst_req_ready",  64'(req_ready),  64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data",  64'(resp_data),  64'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single INSTR, then ready returns two cycles after accept
        push_iss(ACT_INSTR, 2'd0, 5'd5, 32'h0000_E081);
        send(0, ACT_INSTR, 2'd0, 5'd5, 32'h0000_E081);
        req_index[4:0] = 5'd6;
        req_din[31:0]  = 32'h0000_0001;
        req_valid[0]   = 1'b1;
        #1;
        chk("ready_in_issue", 64'(req_ready[0]), 64'd0);
        @(negedge clk);
        #1;
        chk("ready_in_settle", 64'(req_ready[0]), 64'd0);
        @(negedge clk);
        #1;
        chk("ready_again", 64'(req_ready[0]), 64'd1);
        push_iss(ACT_INSTR, 2'd0, 5'd6, 32'h0000_0001);
        send(0, ACT_INSTR, 2'd0, 5'd6, 32'h0000_0001);

        // contending GRPS; pointer starts at 1 after req0's last grant
        push_iss(ACT_GRPS, 2'd0, 5'd0, 32'h0000_00B0);
        push_iss(ACT_GRPS, 2'd0, 5'd0, 32'h0000_00A0);
        push_iss(ACT_GRPS, 2'd0, 5'd0, 32'h0000_00B1);
        push_iss(ACT_GRPS, 2'd0, 5'd0, 32'h0000_00A1);
        fork
            begin
                send(0, ACT_GRPS, 2'd0, 5'd0, 32'h0000_00A0);
                send(0, ACT_GRPS, 2'd0, 5'd0, 32'h0000_00A1);
            end
            begin
                send(1, ACT_GRPS, 2'd0, 5'd0, 32'h0000_00B0);
                send(1, ACT_GRPS, 2'd0, 5'd0, 32'h0000_00B1);
            end
        join
        repeat (3) @(negedge clk);

        // four PUSHes then a PULL that returns pio_dout
        for (int k = 0; k < 4; k++) begin
            push_iss(ACT_PUSH, 2'd2, 5'd0, 32'h1234_5678);
            send(1, ACT_PUSH, 2'd2, 5'd0, 32'h1234_5678);
        end
        pio_rx_empty = 4'b1011;
        pio_dout     = 32'hCAFE_F00D;
        push_iss(ACT_PULL, 2'd2, 5'd0, 32'h0);
        push_rsp(0, 32'hCAFE_F00D);
        send(0, ACT_PULL, 2'd2, 5'd0, 32'h0);
        repeat (4) @(negedge clk);
        pio_rx_empty = '1;

        // req0 PUSH blocked by tx_full[1] while req1 DIV proceeds
        pio_tx_full = 4'b0010;
        push_iss(ACT_DIV,  2'd0, 5'd0, 32'h0000_00D1);
        push_iss(ACT_PUSH, 2'd1, 5'd0, 32'h0000_00D0);
        fork
            send(0, ACT_PUSH, 2'd1, 5'd0, 32'h0000_00D0);
            begin
                send(1, ACT_DIV, 2'd0, 5'd0, 32'h0000_00D1);
                repeat (2) @(negedge clk);
                #1;
                chk("blocked_push_held", 64'(req_ready[0]), 64'd0);
                @(negedge clk);
                pio_tx_full = '0;
            end
        join
        repeat (3) @(negedge clk);

        // NONE returns the version word; action 13 is swallowed
        pio_dout = PIO_VERSION;
        push_rsp(0, PIO_VERSION);
        send(0, ACT_NONE, 2'd0, 5'd0, 32'h0);
        repeat (4) @(negedge clk);
        send(0, 4'd13, 2'd1, 5'd3, 32'h0000_0055);
        repeat (5) @(negedge clk);

        // reset during RESP of a PULL
        pio_dout     = 32'hDEAD_BEEF;
        pio_rx_empty = 4'b1110;
        push_iss(ACT_PULL, 2'd0, 5'd0, 32'h0);
        send(0, ACT_PULL, 2'd0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_pio_action", 64'(pio_action), 64'd0);
        chk("midrst_pio_din",    64'(pio_din),    64'd0);
        chk("midrst_req_ready",  64'(req_ready),  64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_resp_data",  64'(resp_data),  64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // pointer back at 0: req0 wins the first contention
        push_iss(ACT_EN, 2'd0, 5'd0, 32'h0000_00A2);
        push_iss(ACT_EN, 2'd0, 5'd0, 32'h0000_00B2);
        fork
            send(0, ACT_EN, 2'd0, 5'd0, 32'h0000_00A2);
            send(1, ACT_EN, 2'd0, 5'd0, 32'h0000_00B2);
        join
        repeat (6) @(negedge clk);

        chk("iss_q_drained", 64'(iss_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
